// File: rtl/led_frame_writer.sv
// led_frame_writer
//   Backlight frame writer for an SDBP LED driver. After a configuration
//   hold-off it periodically pulses sdbp_flag and then writes one drive word
//   per zone. Zone grey levels are loaded into a ping-pong buffer. The buffer
//   swaps banks only at a frame start, so a displayed frame never mixes two
//   loads.
// Ports
//   clk, rst_n              : system clock, async active-low reset
//   zin_valid/data/last     : zone load stream (data into the back bank)
//   zin_ready               : low while a completed load waits for its swap
//   mode, bright            : output mode and global brightness, sampled per frame
//   cfg_done                : hold-off elapsed (sticky until reset)
//   frame_tick              : one-cycle pulse at frame start (fcnt==0)
//   sdbp_flag               : driver frame-start flag, fcnt 1..FLAG_LEN
//   wt_en/wt_addr/wt_data   : zone write port, all registered and aligned
module led_frame_writer #(
    parameter int ZONES        = 360,
    parameter int AW           = 10,
    parameter int GW           = 8,
    parameter int DW           = 16,
    parameter int CFG_WAIT     = 2500,
    parameter int FRAME_CYC    = 420000,
    parameter int FLAG_LEN     = 29,
    parameter int CHASE_FRAMES = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          zin_valid,
    input  logic [GW-1:0] zin_data,
    input  logic          zin_last,
    output logic          zin_ready,
    input  logic [1:0]    mode,
    input  logic [7:0]    bright,
    output logic          cfg_done,
    output logic          frame_tick,
    output logic          sdbp_flag,
    output logic          wt_en,
    output logic [AW-1:0] wt_addr,
    output logic [DW-1:0] wt_data
);
    localparam int FCW = $clog2(FRAME_CYC);
    localparam int WCW = $clog2(CFG_WAIT + 1);
    localparam int CCW = $clog2(CHASE_FRAMES + 1);
    localparam int ZW  = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int LW  = AW + 1;  // load pointer must be able to hold ZONES

    localparam logic [FCW-1:0] L_LAST = FCW'(FRAME_CYC - 1);
    localparam logic [FCW-1:0] L_FLAG = FCW'(FLAG_LEN);
    localparam logic [FCW-1:0] L_RD0  = FCW'(FLAG_LEN + 1);
    localparam logic [FCW-1:0] L_RD1  = FCW'(FLAG_LEN + ZONES);
    localparam logic [FCW-1:0] L_WR0  = FCW'(FLAG_LEN + 2);
    localparam logic [FCW-1:0] L_WR1  = FCW'(FLAG_LEN + 1 + ZONES);

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [WCW-1:0]  r_wcnt;
    logic [FCW-1:0]  r_fcnt, w_fnext;
    logic            w_run, w_tick, w_wr, w_rd, w_acc, w_bwr;
    logic [AW-1:0]   w_waddr;
    logic [ZW-1:0]   w_raddr;

    logic [GW-1:0]   r_mem [0:1][0:ZONES-1];
    logic [GW-1:0]   r_rdata, w_zone;
    logic            r_act, r_swap_pend, r_have;
    logic [LW-1:0]   r_lptr;
    logic [AW-1:0]   r_chase;
    logic [CCW-1:0]  r_ccnt;
    logic [1:0]      r_mode;
    logic [7:0]      r_bright;

    logic [15:0]     w_m0;
    logic [GW+7:0]   w_m2;
    logic [DW-1:0]   w_wdata;

    logic            r_cfg_done, r_tick, r_flag, r_en;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT;
        else        r_state <= w_state_nxt;
    end

    // Outputs are registered, so everything is decoded from the fcnt value
    // the next cycle will show (w_fnext), not from r_fcnt.
    always_comb begin
        w_state_nxt = r_state;
        w_fnext     = '0;
        if (r_state == S_WAIT) begin
            if (r_wcnt == WCW'(CFG_WAIT - 1)) w_state_nxt = S_RUN;
        end else begin
            w_fnext = (r_fcnt == L_LAST) ? '0 : r_fcnt + 1'b1;
        end
    end

    assign w_run   = (w_state_nxt == S_RUN);
    assign w_tick  = w_run && (w_fnext == '0);
    assign w_wr    = w_run && (w_fnext >= L_WR0) && (w_fnext <= L_WR1);
    assign w_waddr = AW'(w_fnext - L_WR0);
    // Bank read runs one cycle ahead of the write window (sync-RAM latency).
    assign w_rd    = w_run && (w_fnext >= L_RD0) && (w_fnext <= L_RD1);
    assign w_raddr = ZW'(w_fnext - L_RD0);

    assign w_acc   = zin_valid && !r_swap_pend;
    assign w_bwr   = w_acc && (r_lptr < LW'(ZONES));

    // Buffer banks: no reset, behaves as a simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (w_bwr) r_mem[~r_act][ZW'(r_lptr)] <= zin_data;
        if (w_rd)  r_rdata <= r_mem[r_act][w_raddr];
    end

    always_comb begin
        w_zone = r_have ? r_rdata : '0;
        w_m0   = 16'(r_bright) * 16'd224;
        w_m2   = (GW+8)'(w_zone) * (GW+8)'(r_bright);
        case (r_mode)
            2'd0:    w_wdata = DW'(w_m0);
            2'd1:    w_wdata = (w_waddr == r_chase) ? {DW{1'b1}} : '0;
            2'd2:    w_wdata = DW'(w_m2);
            default: w_wdata = DW'(w_zone) << (DW - GW);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_fcnt      <= '0;
            r_act       <= 1'b0;
            r_swap_pend <= 1'b0;
            r_have      <= 1'b0;
            r_lptr      <= '0;
            r_chase     <= '0;
            r_ccnt      <= '0;
            r_mode      <= '0;
            r_bright    <= '0;
            r_cfg_done  <= 1'b0;
            r_tick      <= 1'b0;
            r_flag      <= 1'b0;
            r_en        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;
            r_fcnt <= w_fnext;

            if (w_tick) begin
                r_mode   <= mode;
                r_bright <= bright;
                if (r_swap_pend) begin
                    r_act  <= ~r_act;
                    r_have <= 1'b1;
                end
                // r_ccnt counts ticks of the current chase step (1..CHASE_FRAMES)
                if (r_ccnt == CCW'(CHASE_FRAMES)) begin
                    r_ccnt  <= CCW'(1);
                    r_chase <= (r_chase == AW'(ZONES - 1)) ? '0 : r_chase + 1'b1;
                end else begin
                    r_ccnt  <= r_ccnt + 1'b1;
                end
            end

            // A pending swap blocks loads, so a new zin_last cannot collide with it.
            if (w_tick && r_swap_pend)     r_swap_pend <= 1'b0;
            else if (w_acc && zin_last)    r_swap_pend <= 1'b1;

            if (w_acc) begin
                if (zin_last)                   r_lptr <= '0;
                else if (r_lptr < LW'(ZONES))   r_lptr <= r_lptr + 1'b1;
            end

            r_cfg_done <= w_run;
            r_tick     <= w_tick;
            r_flag     <= w_run && (w_fnext >= FCW'(1)) && (w_fnext <= L_FLAG);
            r_en       <= w_wr;
            r_addr     <= w_wr ? w_waddr : '0;
            r_data     <= w_wr ? w_wdata : '0;
        end
    end

    assign zin_ready  = !r_swap_pend;
    assign cfg_done   = r_cfg_done;
    assign frame_tick = r_tick;
    assign sdbp_flag  = r_flag;
    assign wt_en      = r_en;
    assign wt_addr    = r_addr;
    assign wt_data    = r_data;

endmodule

// File: tb/tb_led_frame_writer.sv
// Bench for led_frame_writer with a small configuration. A frame-level
// reference model (banks, pending swap, chase position, sampled mode/bright)
// predicts each cycle of a captured frame from the functional rules.
module tb_led_frame_writer;
    localparam int ZONES = 8, AW = 3, GW = 8, DW = 16;
    localparam int CFG_WAIT = 10, FRAME_CYC = 64, FLAG_LEN = 4, CHASE_FRAMES = 2;

    logic          clk, rst_n, zin_valid, zin_last, zin_ready;
    logic [GW-1:0] zin_data;
    logic [1:0]    mode;
    logic [7:0]    bright;
    logic          cfg_done, frame_tick, sdbp_flag, wt_en;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_data;

    led_frame_writer #(
        .ZONES(ZONES), .AW(AW), .GW(GW), .DW(DW), .CFG_WAIT(CFG_WAIT),
        .FRAME_CYC(FRAME_CYC), .FLAG_LEN(FLAG_LEN), .CHASE_FRAMES(CHASE_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .zin_valid(zin_valid), .zin_data(zin_data),
        .zin_last(zin_last), .zin_ready(zin_ready), .mode(mode), .bright(bright),
        .cfg_done(cfg_done), .frame_tick(frame_tick), .sdbp_flag(sdbp_flag),
        .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_bank [2][ZONES];
    int         m_act, m_have, m_pend, m_lptr, m_ticks, m_chase;
    logic [1:0] m_mode;
    logic [7:0] m_bright;

    logic [22:0] cap_v [FRAME_CYC];
    logic        exp_rdy [FRAME_CYC];
    logic        cap_next_tick;
    logic [9:0]  ld_q [$];   // {valid, last, data}

    function automatic void model_reset();
        m_act = 0; m_have = 0; m_pend = 0; m_lptr = 0; m_ticks = 0; m_chase = 0;
    endfunction

    function automatic void model_tick();
        m_ticks++;
        m_chase = ((m_ticks - 1) / CHASE_FRAMES) % ZONES;
        if (m_pend != 0) begin
            m_act  = 1 - m_act;
            m_pend = 0;
            m_have = 1;
        end
        m_mode   = mode;
        m_bright = bright;
    endfunction

    function automatic void model_beat(input logic last, input logic [7:0] d);
        if (m_pend != 0) return;
        if (m_lptr < ZONES) m_bank[1-m_act][m_lptr] = d;
        if (last) begin
            m_pend = 1;
            m_lptr = 0;
        end else if (m_lptr < ZONES) begin
            m_lptr++;
        end
    endfunction

    function automatic logic [DW-1:0] zone_val(input int z);
        int zv;
        zv = (m_have != 0) ? int'(m_bank[m_act][z]) : 0;
        case (m_mode)
            2'd0:    return DW'(224 * int'(m_bright));
            2'd1:    return (z == m_chase) ? 16'hFFFF : 16'h0000;
            2'd2:    return DW'(zv * int'(m_bright));
            default: return DW'(zv * 256);
        endcase
    endfunction

    // {zin_ready, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data} for frame cycle k
    function automatic logic [22:0] exp_vec(input int k);
        logic          en;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        en = (k >= FLAG_LEN + 2) && (k < FLAG_LEN + 2 + ZONES);
        a  = en ? AW'(k - (FLAG_LEN + 2)) : '0;
        d  = en ? zone_val(k - (FLAG_LEN + 2)) : '0;
        return {exp_rdy[k], k == 0, (k >= 1 && k <= FLAG_LEN), en, a, d};
    endfunction

    // Entered at the negedge of a frame_tick cycle; records one full frame,
    // optionally changing mode/bright at cycle chg_k and feeding ld_q from ld_k.
    task automatic frame_scan(input int chg_k, input logic [1:0] nm,
                              input logic [7:0] nb, input int ld_k);
        logic [9:0] e;
        model_tick();
        for (int k = 0; k < FRAME_CYC; k++) begin
            cap_v[k]   = {zin_ready, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data};
            exp_rdy[k] = (m_pend == 0);
            if (k == chg_k) begin
                mode   = nm;
                bright = nb;
            end
            if (k >= ld_k && ld_q.size() > 0 && k < FRAME_CYC - 2) begin
                e = ld_q.pop_front();
                zin_valid = e[9];
                zin_last  = e[8];
                zin_data  = e[7:0];
                if (e[9]) model_beat(e[8], e[7:0]);
            end else begin
                zin_valid = 1'b0;
                zin_last  = 1'b0;
            end
            @(negedge clk);
        end
        cap_next_tick = frame_tick;
    endtask

    task automatic test_reset();
        int n, tick_n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_done, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data} !== '0 || zin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs got %b%b%b%b %h %h rdy=%b exp all 0 rdy=1",
                     cfg_done, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data, zin_ready);
        end
        rst_n  = 1'b1;
        tick_n = 0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (frame_tick && tick_n == 0) tick_n = n;
            if (cfg_done) break;
        end
        checks++;
        if (n != CFG_WAIT) begin
            failures++;
            $display("FAIL cfg_done_edge got %0d exp %0d", n, CFG_WAIT);
        end
        checks++;
        if (tick_n != CFG_WAIT) begin
            failures++;
            $display("FAIL first_tick_edge got %0d exp %0d", tick_n, CFG_WAIT);
        end
        model_reset();
    endtask

    task automatic test_timing_uniform();
        // frame 1: bright changes mid-frame, must not affect this frame
        frame_scan(8, 2'd0, 8'hFF, 999);
        for (int k = 0; k < FRAME_CYC; k++) begin
            checks++;
            if (cap_v[k] !== exp_vec(k)) begin
                failures++;
                $display("FAIL uniform_a k=%0d got %h exp %h", k, cap_v[k], exp_vec(k));
            end
        end
        checks++;
        if (cap_v[FLAG_LEN+2][15:0] !== 16'h7000) begin
            failures++;
            $display("FAIL uniform_0x80 got %h exp 7000", cap_v[FLAG_LEN+2][15:0]);
        end
        checks++;
        if (cap_next_tick !== 1'b1) begin
            failures++;
            $display("FAIL frame_period got %b exp 1", cap_next_tick);
        end
        frame_scan(30, 2'd1, 8'hFF, 999);
        for (int k = 0; k < FRAME_CYC; k++) begin
            checks++;
            if (cap_v[k] !== exp_vec(k)) begin
                failures++;
                $display("FAIL uniform_b k=%0d got %h exp %h", k, cap_v[k], exp_vec(k));
            end
        end
        checks++;
        if (cap_v[FLAG_LEN+9][15:0] !== 16'hDF20) begin
            failures++;
            $display("FAIL uniform_0xFF got %h exp df20", cap_v[FLAG_LEN+9][15:0]);
        end
    endtask

    task automatic test_chase();
        for (int f = 0; f < 17; f++) begin
            frame_scan((f == 16) ? 30 : -1, 2'd2, 8'h02, 999);
            for (int k = 0; k < FRAME_CYC; k++) begin
                checks++;
                if (cap_v[k] !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL chase f=%0d k=%0d got %h exp %h", f, k, cap_v[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_local_dim();
        for (int i = 1; i <= ZONES; i++) ld_q.push_back({1'b1, i == ZONES, 8'(i)});
        for (int f = 0; f < 2; f++) begin
            frame_scan(-1, 2'd2, 8'h02, 20);
            for (int k = 0; k < FRAME_CYC; k++) begin
                checks++;
                if (cap_v[k] !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL local_dim f=%0d k=%0d got %h exp %h", f, k, cap_v[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_overflow_native();
        ld_q.push_back({2'b10, 8'hAB});
        for (int i = 1; i < 10; i++) ld_q.push_back({2'b10, 8'($urandom_range(0, 255))});
        ld_q.push_back({2'b11, 8'($urandom_range(0, 255))});  // last, data dropped
        ld_q.push_back({2'b10, 8'h55});                        // ignored: not ready
        ld_q.push_back({2'b11, 8'h66});
        frame_scan(45, 2'd3, 8'h11, 20);
        for (int k = 0; k < FRAME_CYC; k++) begin
            checks++;
            if (cap_v[k] !== exp_vec(k)) begin
                failures++;
                $display("FAIL overflow k=%0d got %h exp %h", k, cap_v[k], exp_vec(k));
            end
        end
        // short load: zones 3.. keep stale back-bank content
        for (int i = 0; i < 3; i++) ld_q.push_back({1'b1, i == 2, 8'($urandom_range(0, 255))});
        for (int f = 0; f < 2; f++) begin
            frame_scan(-1, 2'd3, 8'h11, 20);
            for (int k = 0; k < FRAME_CYC; k++) begin
                checks++;
                if (cap_v[k] !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL native f=%0d k=%0d got %h exp %h", f, k, cap_v[k], exp_vec(k));
                end
            end
            if (f == 0) begin
                checks++;
                if (cap_v[FLAG_LEN+2][15:0] !== 16'hAB00) begin
                    failures++;
                    $display("FAIL native_ab got %h exp ab00", cap_v[FLAG_LEN+2][15:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < ZONES; i++)
                ld_q.push_back({1'b1, i == ZONES - 1, 8'($urandom_range(0, 255))});
            r = $urandom_range(0, 2);
            frame_scan(30, (r == 0) ? 2'd0 : 2'(r + 1), 8'($urandom_range(0, 255)), 20);
            for (int k = 0; k < FRAME_CYC; k++) begin
                checks++;
                if (cap_v[k] !== exp_vec(k)) begin
                    failures++;
                    $display("FAIL random f=%0d k=%0d got %h exp %h", f, k, cap_v[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_done, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data} !== '0 || zin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_outputs got %b%b%b%b %h %h rdy=%b exp all 0 rdy=1",
                     cfg_done, frame_tick, sdbp_flag, wt_en, wt_addr, wt_data, zin_ready);
        end
        mode   = 2'd2;
        bright = 8'h03;
        @(negedge clk);
        rst_n = 1'b1;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (cfg_done) break;
        end
        checks++;
        if (n != CFG_WAIT) begin
            failures++;
            $display("FAIL reset_mid_cfg got %0d exp %0d", n, CFG_WAIT);
        end
        model_reset();
        frame_scan(-1, 2'd2, 8'h03, 999);
        for (int k = 0; k < FRAME_CYC; k++) begin
            checks++;
            if (cap_v[k] !== exp_vec(k)) begin
                failures++;
                $display("FAIL reset_mid_frame k=%0d got %h exp %h", k, cap_v[k], exp_vec(k));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        zin_valid = 1'b0;
        zin_last  = 1'b0;
        zin_data  = '0;
        mode      = 2'd0;
        bright    = 8'h80;
        model_reset();
        test_reset();
        test_timing_uniform();
        test_chase();
        test_local_dim();
        test_overflow_native();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
